// File: rtl/conv_param.sv
// Streaming 1-D correlation: loads an N-sample vector and an M-tap filter, then
// emits N-M+1 saturated (optionally ReLU'd) dot products over a valid/ready port.
//
// state     | meaning
// S_LOAD    | accepting x and f samples until both buffers are full
// S_COMPUTE | one MAC per cycle through the product register and accumulator
// S_OUTPUT  | holding y_data with y_valid high until accepted
module conv_param #(
  parameter int N    = 12,
  parameter int M    = 5,
  parameter int T    = 10,
  parameter int P    = 23,
  parameter int RELU = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic signed [T-1:0] x_data,
  input  logic                x_valid,
  output logic                x_ready,
  input  logic signed [T-1:0] f_data,
  input  logic                f_valid,
  output logic                f_ready,
  output logic signed [P-1:0] y_data,
  output logic                y_valid,
  input  logic                y_ready
);

  localparam int ACCW = 2*T + $clog2(M);
  localparam int XCW  = $clog2(N+1);
  localparam int FCW  = $clog2(M+1);
  localparam int XIW  = (N > 1) ? $clog2(N) : 1;
  localparam int FIW  = (M > 1) ? $clog2(M) : 1;
  localparam int SW   = $clog2(M+2);

  localparam logic [1:0] S_LOAD    = 2'd0;
  localparam logic [1:0] S_COMPUTE = 2'd1;
  localparam logic [1:0] S_OUTPUT  = 2'd2;

  logic [1:0]             state;
  logic                   active;
  logic [XCW-1:0]         x_cnt;
  logic [FCW-1:0]         f_cnt;
  logic [XIW-1:0]         m_idx;
  logic [SW-1:0]          step;
  logic signed [2*T-1:0]  prod;
  logic                   prod_vld;
  logic signed [ACCW-1:0] acc;
  logic signed [T-1:0]    x_buf [N];
  logic signed [T-1:0]    f_buf [M];
  logic signed [T-1:0]    x_sel;
  logic signed [T-1:0]    f_sel;
  logic signed [P-1:0]    y_sat;
  logic signed [P-1:0]    y_out;
  logic                   x_acc;
  logic                   f_acc;
  logic                   x_full_nxt;
  logic                   f_full_nxt;

  // readies come only from registered state, never from the valids
  assign x_ready = active && (state == S_LOAD) && (x_cnt < XCW'(N));
  assign f_ready = active && (state == S_LOAD) && (f_cnt < FCW'(M));
  assign x_acc   = x_valid && x_ready;
  assign f_acc   = f_valid && f_ready;

  assign x_full_nxt = (x_cnt == XCW'(N)) || (x_acc && (x_cnt == XCW'(N-1)));
  assign f_full_nxt = (f_cnt == FCW'(M)) || (f_acc && (f_cnt == FCW'(M-1)));

  always_ff @(posedge clk) begin
    if (x_acc) x_buf[XIW'(x_cnt)] <= x_data;
    if (f_acc) f_buf[FIW'(f_cnt)] <= f_data;
  end

  always_comb begin
    x_sel = '0;
    f_sel = '0;
    if (step < SW'(M)) begin
      x_sel = x_buf[XIW'(int'(m_idx) + int'(step))];
      f_sel = f_buf[FIW'(step)];
    end
  end

  generate
    if (P < ACCW) begin : g_sat
      localparam logic signed [ACCW-1:0] SAT_MAX = {{(ACCW-P+1){1'b0}}, {(P-1){1'b1}}};
      localparam logic signed [ACCW-1:0] SAT_MIN = {{(ACCW-P+1){1'b1}}, {(P-1){1'b0}}};
      always_comb begin
        if (acc > SAT_MAX)      y_sat = SAT_MAX[P-1:0];
        else if (acc < SAT_MIN) y_sat = SAT_MIN[P-1:0];
        else                    y_sat = acc[P-1:0];
      end
    end else begin : g_ext
      always_comb begin
        y_sat = P'(acc);
      end
    end
  endgenerate

  assign y_out = ((RELU != 0) && y_sat[P-1]) ? '0 : y_sat;

  // step 0..M-1 issues products, step M drains the last one, step M+1 publishes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_LOAD;
      active   <= 1'b0;
      x_cnt    <= '0;
      f_cnt    <= '0;
      m_idx    <= '0;
      step     <= '0;
      prod     <= '0;
      prod_vld <= 1'b0;
      acc      <= '0;
      y_data   <= '0;
      y_valid  <= 1'b0;
    end else begin
      active   <= 1'b1;
      prod_vld <= 1'b0;
      case (state)
        S_LOAD: begin
          if (x_acc) x_cnt <= x_cnt + XCW'(1);
          if (f_acc) f_cnt <= f_cnt + FCW'(1);
          if (x_full_nxt && f_full_nxt) begin
            state <= S_COMPUTE;
            step  <= '0;
            acc   <= '0;
          end
        end
        S_COMPUTE: begin
          if (step < SW'(M)) begin
            prod     <= (2*T)'(x_sel) * (2*T)'(f_sel);
            prod_vld <= 1'b1;
          end
          if (prod_vld) acc <= acc + ACCW'(prod);
          if (step == SW'(M+1)) begin
            y_data  <= y_out;
            y_valid <= 1'b1;
            state   <= S_OUTPUT;
          end else begin
            step <= step + SW'(1);
          end
        end
        S_OUTPUT: begin
          if (y_ready) begin
            y_valid <= 1'b0;
            step    <= '0;
            acc     <= '0;
            if (m_idx == XIW'(N-M)) begin
              state <= S_LOAD;
              x_cnt <= '0;
              f_cnt <= '0;
              m_idx <= '0;
            end else begin
              m_idx <= m_idx + XIW'(1);
              state <= S_COMPUTE;
            end
          end
        end
        default: state <= S_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_param.sv
// Directed bench for conv_param: default, RELU=1 and P=12 instances run in lockstep
// on shared stimulus; each test task checks its own expectations inline.
module tb_conv_param;

  localparam int N    = 12;
  localparam int M    = 5;
  localparam int T    = 10;
  localparam int NOUT = N - M + 1;

  localparam int SET1_X [N] = '{10, -20, 30, -40, 50, 60, 70, 80, -90, 100, -110, 120};
  localparam int SET1_F [M] = '{10, 20, -30, 40, -50};
  localparam int SET1_Y [NOUT] = '{-5300, 600, -3100, -2400, 7300, -9000, 14500, -14400};
  localparam int SET1_R [NOUT] = '{0, 600, 0, 0, 7300, 0, 14500, 0};
  localparam int SET1_P [NOUT] = '{-2048, 600, -2048, -2048, 2047, -2048, 2047, -2048};

  localparam int SET2_X [N] = '{-50, 40, 30, -20, -10, 0, -10, 20, -30, -40, -50, -60};
  localparam int SET2_F [M] = '{-60, 70, 80, -90, 100};
  localparam int SET2_Y [NOUT] = '{9000, -1000, -5000, 3400, -5000, -400, -1800, -8000};
  localparam int SET2_R [NOUT] = '{9000, 0, 0, 3400, 0, 0, 0, 0};
  localparam int SET2_P [NOUT] = '{2047, -1000, -2048, 2047, -2048, -400, -1800, -2048};

  logic clk;
  logic reset;
  logic signed [T-1:0] x_data;
  logic signed [T-1:0] f_data;
  logic x_valid, f_valid, y_ready;
  logic x_ready, f_ready, y_valid;
  logic signed [22:0] y_data;
  logic x_ready_r, f_ready_r, y_valid_r;
  logic signed [22:0] y_data_r;
  logic x_ready_p, f_ready_p, y_valid_p;
  logic signed [11:0] y_data_p;

  int n_checks = 0;
  int n_pass   = 0;
  int xs_cur [N];
  int fs_cur [M];
  logic signed [22:0] got_def  [NOUT];
  logic signed [22:0] got_relu [NOUT];
  logic signed [11:0] got_p12  [NOUT];
  int n_out;
  int desync;

  conv_param u_def (
    .clk(clk), .reset(reset),
    .x_data(x_data), .x_valid(x_valid), .x_ready(x_ready),
    .f_data(f_data), .f_valid(f_valid), .f_ready(f_ready),
    .y_data(y_data), .y_valid(y_valid), .y_ready(y_ready)
  );

  conv_param #(.RELU(1)) u_relu (
    .clk(clk), .reset(reset),
    .x_data(x_data), .x_valid(x_valid), .x_ready(x_ready_r),
    .f_data(f_data), .f_valid(f_valid), .f_ready(f_ready_r),
    .y_data(y_data_r), .y_valid(y_valid_r), .y_ready(y_ready)
  );

  conv_param #(.P(12)) u_p12 (
    .clk(clk), .reset(reset),
    .x_data(x_data), .x_valid(x_valid), .x_ready(x_ready_p),
    .f_data(f_data), .f_valid(f_valid), .f_ready(f_ready_p),
    .y_data(y_data_p), .y_valid(y_valid_p), .y_ready(y_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one full set from xs_cur/fs_cur and captures every accepted output.
  task automatic run_set(input bit rnd, input int budget);
    int xi, fi, cyc;
    bit xa, fa, ya;
    xi = 0; fi = 0; cyc = 0; n_out = 0; desync = 0;
    while (n_out < NOUT && cyc < budget) begin
      x_valid = (xi < N) && (!rnd || $urandom_range(0, 1) == 1);
      f_valid = (fi < M) && (!rnd || $urandom_range(0, 1) == 1);
      x_data  = T'($urandom);
      f_data  = T'($urandom);
      if (x_valid) x_data = T'(xs_cur[xi]);
      if (f_valid) f_data = T'(fs_cur[fi]);
      y_ready = !rnd || ($urandom_range(0, 2) != 0);
      if (x_ready_r !== x_ready || x_ready_p !== x_ready || f_ready_r !== f_ready ||
          f_ready_p !== f_ready || y_valid_r !== y_valid || y_valid_p !== y_valid)
        desync++;
      xa = x_valid && x_ready;
      fa = f_valid && f_ready;
      ya = y_valid && y_ready;
      if (ya) begin
        got_def[n_out]  = y_data;
        got_relu[n_out] = y_data_r;
        got_p12[n_out]  = y_data_p;
        n_out++;
      end
      @(posedge clk); #1;
      if (xa) xi++;
      if (fa) fi++;
      cyc++;
    end
    x_valid = 1'b0;
    f_valid = 1'b0;
    y_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; x_valid = 1'b0; f_valid = 1'b0; y_ready = 1'b0;
    x_data = '0; f_data = '0;
    #2;
    n_checks++;
    if ({x_ready, f_ready, y_valid} !== 3'b000 || y_data !== 23'sd0)
      $display("FAIL reset_outputs: got rdy/vld=%b%b%b y=%0d, expected 000 y=0",
               x_ready, f_ready, y_valid, y_data);
    else n_pass++;
    @(posedge clk); @(posedge clk); #3;
    reset = 1'b0;
    #1;
    n_checks++;
    if ({x_ready, f_ready} !== 2'b00)
      $display("FAIL ready_before_edge: got %b%b, expected 00", x_ready, f_ready);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if ({x_ready, f_ready, y_valid} !== 3'b110)
      $display("FAIL ready_after_edge: got rdy/vld=%b%b%b, expected 110", x_ready, f_ready, y_valid);
    else n_pass++;
  endtask

  task automatic test_timing();
    int xi, fi, lat, k, guard;
    bit xa, fa;
    xi = 0; fi = 0; guard = 0;
    y_ready = 1'b1;
    while ((xi < N || fi < M) && guard < 100) begin
      x_valid = (xi < N);
      f_valid = (fi < M);
      x_data = '0; f_data = '0;
      if (x_valid) x_data = T'(SET1_X[xi]);
      if (f_valid) f_data = T'(SET1_F[fi]);
      xa = x_valid && x_ready;
      fa = f_valid && f_ready;
      @(posedge clk); #1;
      if (xa) xi++;
      if (fa) fi++;
      guard++;
    end
    x_valid = 1'b0; f_valid = 1'b0;
    lat = 0;
    while (!y_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    n_checks++;
    if (lat !== M + 2) $display("FAIL first_latency: got %0d cycles, expected %0d", lat, M + 2);
    else n_pass++;
    n_checks++;
    if (int'(y_data) !== SET1_Y[0] || int'(y_data_r) !== SET1_R[0] || int'(y_data_p) !== SET1_P[0])
      $display("FAIL first_value: got %0d/%0d/%0d, expected %0d/%0d/%0d",
               y_data, y_data_r, y_data_p, SET1_Y[0], SET1_R[0], SET1_P[0]);
    else n_pass++;
    @(posedge clk); #1;
    y_ready = 1'b0;
    lat = 0;
    while (!y_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    n_checks++;
    if (lat !== M + 2) $display("FAIL next_latency: got %0d cycles, expected %0d", lat, M + 2);
    else n_pass++;
    for (int c = 0; c < 20; c++) begin
      n_checks++;
      if ({y_valid, x_ready, f_ready} !== 3'b100 || int'(y_data) !== SET1_Y[1])
        $display("FAIL hold_cycle%0d: got vld/xr/fr=%b%b%b y=%0d, expected 100 y=%0d",
                 c, y_valid, x_ready, f_ready, y_data, SET1_Y[1]);
      else n_pass++;
      @(posedge clk); #1;
    end
    y_ready = 1'b1;
    k = 1; guard = 0;
    while (k < NOUT && guard < 200) begin
      if (y_valid) begin
        n_checks++;
        if (int'(y_data) !== SET1_Y[k])
          $display("FAIL drain_y%0d: got %0d, expected %0d", k, y_data, SET1_Y[k]);
        else n_pass++;
        k++;
      end
      @(posedge clk); #1;
      guard++;
    end
    y_ready = 1'b0;
    n_checks++;
    if (k !== NOUT || x_ready !== 1'b1 || y_valid !== 1'b0)
      $display("FAIL drain_end: got k=%0d xr=%b vld=%b, expected k=%0d xr=1 vld=0",
               k, x_ready, y_valid, NOUT);
    else n_pass++;
  endtask

  task automatic test_random_set();
    int idle_hits;
    xs_cur = SET1_X; fs_cur = SET1_F;
    run_set(1'b1, 4000);
    n_checks++;
    if (n_out !== NOUT) $display("FAIL set1_count: got %0d, expected %0d", n_out, NOUT);
    else n_pass++;
    n_checks++;
    if (desync !== 0) $display("FAIL set1_lockstep: got %0d divergent cycles, expected 0", desync);
    else n_pass++;
    for (int i = 0; i < NOUT; i++) begin
      n_checks++;
      if (int'(got_def[i]) !== SET1_Y[i])
        $display("FAIL set1_y%0d: got %0d, expected %0d", i, got_def[i], SET1_Y[i]);
      else n_pass++;
      n_checks++;
      if (int'(got_relu[i]) !== SET1_R[i])
        $display("FAIL set1_relu%0d: got %0d, expected %0d", i, got_relu[i], SET1_R[i]);
      else n_pass++;
      n_checks++;
      if (int'(got_p12[i]) !== SET1_P[i])
        $display("FAIL set1_p12_%0d: got %0d, expected %0d", i, got_p12[i], SET1_P[i]);
      else n_pass++;
    end
    idle_hits = 0;
    y_ready = 1'b1;
    for (int c = 0; c < 100; c++) begin
      if (y_valid) idle_hits++;
      @(posedge clk); #1;
    end
    y_ready = 1'b0;
    n_checks++;
    if (idle_hits !== 0) $display("FAIL idle_no_output: got %0d valid cycles, expected 0", idle_hits);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    xs_cur = SET2_X; fs_cur = SET2_F;
    run_set(1'b1, 4000);
    n_checks++;
    if (n_out !== NOUT || desync !== 0)
      $display("FAIL set2_count: got %0d outputs desync=%0d, expected %0d desync=0", n_out, desync, NOUT);
    else n_pass++;
    for (int i = 0; i < NOUT; i++) begin
      n_checks++;
      if (int'(got_def[i]) !== SET2_Y[i] || int'(got_relu[i]) !== SET2_R[i] || int'(got_p12[i]) !== SET2_P[i])
        $display("FAIL set2_y%0d: got %0d/%0d/%0d, expected %0d/%0d/%0d", i,
                 got_def[i], got_relu[i], got_p12[i], SET2_Y[i], SET2_R[i], SET2_P[i]);
      else n_pass++;
    end
    xs_cur = SET1_X; fs_cur = SET1_F;
    run_set(1'b1, 4000);
    n_checks++;
    if (n_out !== NOUT) $display("FAIL set3_count: got %0d, expected %0d", n_out, NOUT);
    else n_pass++;
    for (int i = 0; i < NOUT; i++) begin
      n_checks++;
      if (int'(got_def[i]) !== SET1_Y[i])
        $display("FAIL set3_y%0d: got %0d, expected %0d", i, got_def[i], SET1_Y[i]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    int xi, fi;
    bit xa, fa;
    xi = 0; fi = 0;
    for (int c = 0; c < 40 && (xi < 7 || fi < 3); c++) begin
      x_valid = (xi < 7);
      f_valid = (fi < 3);
      x_data = '0; f_data = '0;
      if (x_valid) x_data = T'(SET2_X[xi]);
      if (f_valid) f_data = T'(SET2_F[fi]);
      xa = x_valid && x_ready;
      fa = f_valid && f_ready;
      @(posedge clk); #1;
      if (xa) xi++;
      if (fa) fi++;
    end
    x_valid = 1'b0; f_valid = 1'b0;
    n_checks++;
    if (xi !== 7 || fi !== 3) $display("FAIL partial_load: got x=%0d f=%0d, expected x=7 f=3", xi, fi);
    else n_pass++;
    reset = 1'b1;
    #2;
    n_checks++;
    if ({x_ready, f_ready, y_valid} !== 3'b000 || y_data !== 23'sd0)
      $display("FAIL midreset_outputs: got rdy/vld=%b%b%b y=%0d, expected 000 y=0",
               x_ready, f_ready, y_valid, y_data);
    else n_pass++;
    @(posedge clk); @(posedge clk); #3;
    reset = 1'b0;
    #1;
    n_checks++;
    if ({x_ready, f_ready} !== 2'b00) $display("FAIL midreset_release: got %b%b, expected 00", x_ready, f_ready);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if ({x_ready, f_ready} !== 2'b11) $display("FAIL midreset_ready: got %b%b, expected 11", x_ready, f_ready);
    else n_pass++;
    xs_cur = SET1_X; fs_cur = SET1_F;
    run_set(1'b1, 4000);
    n_checks++;
    if (n_out !== NOUT) $display("FAIL postreset_count: got %0d, expected %0d", n_out, NOUT);
    else n_pass++;
    for (int i = 0; i < NOUT; i++) begin
      n_checks++;
      if (int'(got_def[i]) !== SET1_Y[i])
        $display("FAIL postreset_y%0d: got %0d, expected %0d", i, got_def[i], SET1_Y[i]);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_timing();
    test_random_set();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/conv_param.md
CONV_PARAM -- requirements
Module: conv_param

Interface
REQ-001 SHALL have parameter N, default 12: input vector length.
REQ-002 SHALL have parameter M, default 5: filter length; legal range 1 <= M <= N.
REQ-003 SHALL have parameter T, default 10: signed input width.
REQ-004 SHALL have parameter P, default 23: signed output width.
REQ-005 SHALL have parameter RELU, default 0: 1 = clamp negative results to 0.
REQ-006 SHALL have port clk  in  1: sole clock, all state on rising edge.
REQ-007 SHALL have port reset  in  1: asynchronous, active-high reset.
REQ-008 SHALL have port x_data  in  T: signed input vector sample.
REQ-009 SHALL have ports x_valid in 1 and x_ready out 1: x handshake.
REQ-010 SHALL have port f_data  in  T: signed filter coefficient.
REQ-011 SHALL have ports f_valid in 1 and f_ready out 1: f handshake.
REQ-012 SHALL have port y_data  out  P: signed result.
REQ-013 SHALL have ports y_valid out 1 and y_ready in 1: y handshake.

Function
REQ-014 SHALL accept a transfer on any channel only at a rising edge where valid and ready are both 1; x_data/f_data SHALL be ignored otherwise (may be X).
REQ-015 SHALL run FSM states LOAD, COMPUTE, OUTPUT.
REQ-016 LOAD: x_ready = 1 while fewer than N x samples are stored; f_ready = 1 while fewer than M coefficients are stored; x and f SHALL load independently and concurrently, in arrival order.
REQ-017 LOAD -> COMPUTE at the edge after both buffers are full; x_ready and f_ready SHALL be 0 in COMPUTE and OUTPUT.
REQ-018 For output index m = 0..N-M: y[m] = sum over j = 0..M-1 of x[m+j]*f[j] (correlation, no filter reversal).
REQ-019 COMPUTE SHALL perform one multiply-accumulate per cycle, with a registered product stage; the first y_valid SHALL rise exactly M+2 cycles after the edge accepting the last input of the set.
REQ-020 Products SHALL be 2T bits signed; the accumulator SHALL be 2T+clog2(M) bits signed, so no internal overflow.
REQ-021 Result SHALL saturate to the P-bit signed range [-2^(P-1), 2^(P-1)-1] when P is less than the accumulator width, and sign-extend otherwise.
REQ-022 When RELU = 1, negative results SHALL be output as 0; ReLU SHALL be applied after saturation.
REQ-023 OUTPUT: y_valid = 1 with y_data stable until the accepting edge (y_valid & y_ready).
REQ-024 After acceptance of y[m] with m < N-M: COMPUTE for y[m+1]; each subsequent y_valid SHALL rise exactly M+2 cycles after the accepting edge.
REQ-025 After acceptance of y[N-M]: return to LOAD with both counts 0; y_valid SHALL stay 0 until a full new set is loaded.
REQ-026 Exactly N-M+1 outputs SHALL be produced per loaded set; no output SHALL be duplicated or skipped under any y_ready pattern.
REQ-027 y_valid SHALL never depend combinationally on y_ready; x_ready/f_ready SHALL never depend combinationally on x_valid/f_valid.

Reset
REQ-028 While reset = 1, asynchronously: state = LOAD, counts = 0, accumulator = 0, x_ready = 0, f_ready = 0, y_valid = 0, y_data = 0.
REQ-029 x_ready and f_ready SHALL rise on the first edge after reset deasserts.
REQ-030 Reset in any state SHALL discard partial inputs and pending results; no stale y SHALL appear afterwards.

Verification
REQ-031 Defaults, random valid/ready; x = 10,-20,30,-40,50,60,70,80,-90,100,-110,120, f = 10,20,-30,40,-50 -> y = -5300,600,-3100,-2400,7300,-9000,14500,-14400; then no y_valid for 100 cycles.
REQ-032 Back-to-back second set; x = -50,40,30,-20,-10,0,-10,20,-30,-40,-50,-60, f = -60,70,80,-90,100 -> y = 9000,-1000,-5000,3400,-5000,-400,-1800,-8000.
REQ-033 RELU = 1 with the REQ-031 vectors -> y = 0,600,0,0,7300,0,14500,0.
REQ-034 P = 12 with the REQ-031 vectors -> y = -2048,600,-2048,-2048,2047,-2048,2047,-2048.
REQ-035 All valid/ready held high, defaults -> y[0] valid exactly 7 cycles after the last accepting edge; hold y_ready = 0 for 20 cycles -> y_data stable, x_ready = f_ready = 0.
REQ-036 Load 7 x and 3 f, pulse reset, then the full REQ-031 set -> exactly the REQ-031 outputs.
